// File: rtl/sumador_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : sumador_pkg
//  Description : Shared constants for the serial subtractor slice.
//  Revision    : 1.0 - initial release
// ============================================================================
package sumador_pkg;

    localparam int DEFAULT_WIDTH = 8;

    typedef logic [1:0] state_t;

    localparam state_t ST_IDLE = 2'd0;
    localparam state_t ST_RUN  = 2'd1;
    localparam state_t ST_DONE = 2'd2;

endpackage
`default_nettype wire

// File: rtl/full_subtractor.sv
`default_nettype none
// ============================================================================
//  Module      : full_subtractor
//  Description : Combinational 1-bit full-subtractor cell (a - b - bin).
//  Revision    : 1.0 - initial release
// ============================================================================
module full_subtractor (
    input  logic a,
    input  logic b,
    input  logic bin,
    output logic d,
    output logic bout
);

    logic w_axb;

    assign w_axb = a ^ b;
    assign d     = w_axb ^ bin;
    assign bout  = (~a & b) | (~w_axb & bin);

endmodule
`default_nettype wire

// File: rtl/serial_subtractor.sv
`default_nettype none
// ============================================================================
//  Module      : serial_subtractor
//  Description : Bit-serial LSB-first two's-complement subtractor A - B - bin.
//  Revision    : 1.0 - initial release
// ============================================================================
module serial_subtractor
    import sumador_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             borrow_in,
    input  logic             bit_valid,
    input  logic             a_bit,
    input  logic             b_bit,
    output logic             busy,
    output logic             diff_bit,
    output logic             diff_valid,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             borrow_out,
    output logic             overflow
);

    localparam int             CW     = $clog2(WIDTH + 1);
    localparam logic [CW-1:0]  C_FULL = CW'(WIDTH);
    localparam logic [CW-1:0]  C_LAST = CW'(WIDTH - 1);

    state_t            r_state;
    logic [CW-1:0]     r_count;
    logic              r_borrow_q;
    logic [WIDTH-1:0]  r_result;
    logic              r_diff_bit;
    logic              r_diff_valid;
    logic              r_borrow_out;
    logic              r_overflow;

    logic              w_d;
    logic              w_bnext;
    logic              w_accept;

    full_subtractor u_cell (
        .a    (a_bit),
        .b    (b_bit),
        .bin  (r_borrow_q),
        .d    (w_d),
        .bout (w_bnext)
    );

    // Count guard keeps the counter from ever passing WIDTH.
    assign w_accept = (r_state == ST_RUN) && bit_valid && (r_count < C_FULL);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= ST_IDLE;
            r_count      <= '0;
            r_borrow_q   <= 1'b0;
            r_result     <= '0;
            r_diff_bit   <= 1'b0;
            r_diff_valid <= 1'b0;
            r_borrow_out <= 1'b0;
            r_overflow   <= 1'b0;
        end else begin
            r_diff_valid <= w_accept;
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_state      <= ST_RUN;
                        r_borrow_q   <= borrow_in;
                        r_count      <= '0;
                        r_result     <= '0;
                        r_borrow_out <= 1'b0;
                        r_overflow   <= 1'b0;
                    end
                end
                ST_RUN: begin
                    if (w_accept) begin
                        r_borrow_q <= w_bnext;
                        r_result   <= {w_d, r_result[WIDTH-1:1]};
                        r_diff_bit <= w_d;
                        r_count    <= r_count + 1'b1;
                        if (r_count == C_LAST) begin
                            r_borrow_out <= w_bnext;
                            // Borrow into the MSB differs from borrow out of it.
                            r_overflow   <= r_borrow_q ^ w_bnext;
                            r_state      <= ST_DONE;
                        end
                    end
                end
                ST_DONE: begin
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign busy       = (r_state != ST_IDLE);
    assign done       = (r_state == ST_DONE);
    assign diff_bit   = r_diff_bit;
    assign diff_valid = r_diff_valid;
    assign result     = r_result;
    assign borrow_out = r_borrow_out;
    assign overflow   = r_overflow;

endmodule
`default_nettype wire

// File: tb/tb_serial_subtractor.sv
`default_nettype none
// ============================================================================
//  Module      : tb_serial_subtractor
//  Description : Directed scoreboard bench for serial_subtractor (WIDTH=8).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_serial_subtractor;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         start;
    logic         borrow_in;
    logic         bit_valid;
    logic         a_bit;
    logic         b_bit;
    logic         busy;
    logic         diff_bit;
    logic         diff_valid;
    logic         done;
    logic [W-1:0] result;
    logic         borrow_out;
    logic         overflow;

    int   checks   = 0;
    int   errors   = 0;
    int   dv_cnt   = 0;
    int   done_cnt = 0;
    logic exp_q[$];

    always #5 clk = ~clk;

    serial_subtractor #(.WIDTH(W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .borrow_in  (borrow_in),
        .bit_valid  (bit_valid),
        .a_bit      (a_bit),
        .b_bit      (b_bit),
        .busy       (busy),
        .diff_bit   (diff_bit),
        .diff_valid (diff_valid),
        .done       (done),
        .result     (result),
        .borrow_out (borrow_out),
        .overflow   (overflow)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Scoreboard: every diff_valid pulse pops the next expected difference bit.
    always @(negedge clk) begin
        if (rst_n) begin
            if (done) done_cnt++;
            if (diff_valid) begin
                dv_cnt++;
                if (exp_q.size() == 0) chk("diff_extra", 32'd1, 32'd0);
                else                   chk("diff_bit", {31'd0, diff_bit}, {31'd0, exp_q.pop_front()});
            end
        end
    end

    task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic bin, input bit stall, input string tag);
        logic [W-1:0] e_res;
        logic         e_bo;
        logic         e_ov;
        int           sd;
        int           dv0;
        int           dn0;
        int           ncyc;
        e_res = a - b - W'(bin);
        e_bo  = (int'(a) < int'(b) + int'(bin));
        sd    = int'($signed(a)) - int'($signed(b)) - int'(bin);
        e_ov  = (sd < -128) || (sd > 127);
        dv0   = dv_cnt;
        dn0   = done_cnt;

        // Start cycle also carries a junk valid bit that must be ignored.
        @(negedge clk);
        start = 1'b1; borrow_in = bin; bit_valid = 1'b1; a_bit = 1'b1; b_bit = 1'b1;
        ncyc = 1;
        @(negedge clk);
        ncyc++;
        start = 1'b0; borrow_in = ~bin;
        chk({tag, "_busy_run"}, {31'd0, busy}, 32'd1);
        for (int i = 0; i < W; i++) begin
            if (stall) begin
                bit_valid = 1'b0; start = 1'b1; a_bit = ~a[i]; b_bit = ~b[i];
                @(negedge clk);
                ncyc++;
                start = 1'b0;
            end
            bit_valid = 1'b1; a_bit = a[i]; b_bit = b[i];
            exp_q.push_back(e_res[i]);
            @(negedge clk);
            ncyc++;
            bit_valid = 1'b0;
            chk({tag, "_done"}, {31'd0, done}, (i == W - 1) ? 32'd1 : 32'd0);
        end
        if (!stall) chk({tag, "_latency"}, ncyc, W + 2);
        chk({tag, "_result"},   {24'd0, result},     {24'd0, e_res});
        chk({tag, "_borrow"},   {31'd0, borrow_out}, {31'd0, e_bo});
        chk({tag, "_overflow"}, {31'd0, overflow},   {31'd0, e_ov});
        chk({tag, "_dv_last"},  {31'd0, diff_valid}, 32'd1);
        @(negedge clk);
        chk({tag, "_done_off"}, {31'd0, done},       32'd0);
        chk({tag, "_idle"},     {31'd0, busy},       32'd0);
        chk({tag, "_held"},     {24'd0, result},     {24'd0, e_res});
        chk({tag, "_held_bo"},  {31'd0, borrow_out}, {31'd0, e_bo});
        chk({tag, "_dv_count"}, dv_cnt - dv0,        W);
        chk({tag, "_done_cnt"}, done_cnt - dn0,      32'd1);
        chk({tag, "_sb_empty"}, exp_q.size(),        32'd0);
    endtask

    initial begin
        int dn0;
        rst_n = 1'b0; start = 1'b0; borrow_in = 1'b0; bit_valid = 1'b0;
        a_bit = 1'b0; b_bit = 1'b0;
        #1;
        chk("rst_busy",   {31'd0, busy},       32'd0);
        chk("rst_done",   {31'd0, done},       32'd0);
        chk("rst_dv",     {31'd0, diff_valid}, 32'd0);
        chk("rst_result", {24'd0, result},     32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        // Idle cycles with borrow_in and bit_valid high but no start.
        borrow_in = 1'b1; bit_valid = 1'b1;
        @(negedge clk);
        chk("idle_no_start", {31'd0, busy}, 32'd0);
        borrow_in = 1'b0; bit_valid = 1'b0;

        run_op(8'h5A, 8'h3C, 1'b0, 1'b0, "t1");
        run_op(8'h00, 8'h01, 1'b0, 1'b0, "t2");
        run_op(8'h80, 8'h01, 1'b0, 1'b0, "t3");
        run_op(8'h10, 8'h0F, 1'b1, 1'b0, "t4");
        run_op(8'h5A, 8'h3C, 1'b0, 1'b1, "t5");
        run_op(8'h7F, 8'hFF, 1'b1, 1'b1, "t5b");

        // Abort after three accepted bits.
        dn0 = done_cnt;
        @(negedge clk);
        start = 1'b1; borrow_in = 1'b0;
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < 3; i++) begin
            bit_valid = 1'b1; a_bit = 1'b1; b_bit = 1'b0;
            exp_q.push_back(1'b1);
            @(negedge clk);
        end
        bit_valid = 1'b1;
        #2;
        rst_n = 1'b0;
        #1;
        exp_q.delete();
        chk("abort_busy",   {31'd0, busy},       32'd0);
        chk("abort_dv",     {31'd0, diff_valid}, 32'd0);
        chk("abort_done",   {31'd0, done},       32'd0);
        chk("abort_result", {24'd0, result},     32'd0);
        chk("abort_diff",   {31'd0, diff_bit},   32'd0);
        bit_valid = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        chk("abort_no_done", done_cnt - dn0, 32'd0);
        chk("abort_idle",    {31'd0, busy},  32'd0);

        run_op(8'hC3, 8'h3C, 1'b0, 1'b0, "t6");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
